// File: rtl/mmio_uart_tx_if.sv
// Data-memory bus bundle for the mmio_uart_tx responder.
// The cpu side is the master; the peripheral answers with rd_data and hit.
interface mmio_uart_tx_if;
    logic        wr_sig;
    logic [31:0] wr_data;
    logic [31:0] addr;
    logic [31:0] rd_data;
    logic        hit;

    modport master (output wr_sig, wr_data, addr, input rd_data, hit);
    modport slave  (input wr_sig, wr_data, addr, output rd_data, hit);
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO and programmable baud divisor.
// Optional UART_TX_IRQ_EN adds a registered irq output and the STATUS irq_en bit.
//
//   state | meaning
//   IDLE  | line high; pops the FIFO head and latches the divisor when data is queued
//   START | start bit (low) for div cycles
//   DATA  | eight data bits, LSB first, div cycles each
//   STOP  | stop bit (high) for div cycles
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic           clk,
    input  logic           reset_n,
    mmio_uart_tx_if.slave  bus,
    output logic           tx
`ifdef UART_TX_IRQ_EN
    ,
    output logic           irq
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          irq_en;
    logic [15:0]   divisor;
    logic [15:0]   div_eff;
    logic [15:0]   div_shadow;
    logic [15:0]   cnt;
    logic [7:0]    shift;
    logic [2:0]    bit_idx;

    logic [1:0]    sel;
    logic          wr_en;
    logic          push;
    logic          pop;
    logic          status_wr;
    logic          div_wr;
    logic          empty;
    logic          full;
    logic          busy;
    logic          unused_bits;

    assign sel       = bus.addr[3:2];
    assign bus.hit   = (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign wr_en     = bus.wr_sig & bus.hit;
    assign push      = wr_en & (sel == 2'd0);
    assign status_wr = wr_en & (sel == 2'd1);
    assign div_wr    = wr_en & (sel == 2'd2);
    assign empty     = (count == '0);
    assign full      = (count == CW'(FIFO_DEPTH));
    assign busy      = (state != IDLE);
    assign pop       = (state == IDLE) & ~empty;
    assign div_eff   = (divisor == 16'd0) ? 16'd1 : divisor;

    assign unused_bits = ^{bus.wr_data[31:16], bus.addr[1:0]};

    always_comb begin
        bus.rd_data = 32'd0;
        if (bus.hit) begin
            case (sel)
                2'd1:    bus.rd_data = {27'd0, irq_en, overflow, busy, full, empty};
                2'd2:    bus.rd_data = {16'd0, divisor};
                default: bus.rd_data = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            fifo_mem[wr_ptr] <= bus.wr_data[7:0];
        end
    end

    // A push into a full FIFO is dropped even when a pop frees a slot the same cycle.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push & ~full, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push && full) begin
                overflow <= 1'b1;
            end else if (status_wr && bus.wr_data[3]) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            divisor <= DEFAULT_DIV;
        end else if (div_wr) begin
            divisor <= bus.wr_data[15:0];
        end
    end

`ifdef UART_TX_IRQ_EN
    always_ff @(posedge clk) begin
        if (reset_n) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (status_wr) begin
                irq_en <= bus.wr_data[4];
            end
            irq <= irq_en & empty & ~busy;
        end
    end
`else
    assign irq_en = 1'b0;
`endif

    // tx follows the state one cycle late so the line is always a flop output.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state      <= IDLE;
            tx         <= 1'b1;
            cnt        <= 16'd0;
            div_shadow <= 16'd1;
            shift      <= 8'd0;
            bit_idx    <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (!empty) begin
                        shift      <= fifo_mem[rd_ptr];
                        div_shadow <= div_eff;
                        cnt        <= div_eff - 16'd1;
                        state      <= START;
                    end
                end
                START: begin
                    tx <= 1'b0;
                    if (cnt == 16'd0) begin
                        cnt     <= div_shadow - 16'd1;
                        bit_idx <= 3'd0;
                        state   <= DATA;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                DATA: begin
                    tx <= shift[0];
                    if (cnt == 16'd0) begin
                        cnt   <= div_shadow - 16'd1;
                        shift <= shift >> 1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (cnt == 16'd0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register map, framing, FIFO overflow,
// divisor shadowing, reset abort and (with UART_TX_IRQ_EN) the irq output.
module tb_mmio_uart_tx;

    localparam logic [31:0] A_TX  = 32'h0000_1000;
    localparam logic [31:0] A_ST  = 32'h0000_1004;
    localparam logic [31:0] A_DIV = 32'h0000_1008;
    localparam logic [31:0] A_RES = 32'h0000_100C;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic tx;
`ifdef UART_TX_IRQ_EN
    logic irq;
`endif
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    mmio_uart_tx_if bus ();

    mmio_uart_tx #(
        .BASE_ADDR  (32'h0000_1000),
        .FIFO_DEPTH (8),
        .DEFAULT_DIV(16'd4)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus),
        .tx     (tx)
`ifdef UART_TX_IRQ_EN
        ,
        .irq    (irq)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.addr    = a;
        bus.wr_data = d;
        bus.wr_sig  = 1'b1;
        @(posedge clk);
        #1;
        bus.wr_sig  = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.addr   = a;
        bus.wr_sig = 1'b0;
        #1;
        d = bus.rd_data;
    endtask

    task automatic wait_start(input int bound, output int n, output bit found);
        n = 0;
        found = 1'b0;
        while (!found && n < bound) begin
            @(negedge clk);
            n++;
            if (tx === 1'b0) found = 1'b1;
        end
    endtask

    // Entered on the first low sample; every sample of each bit must hold.
    task automatic verify_frame(input string tag, input logic [7:0] b, input int div);
        logic [9:0] word;
        bit         glitch;
        word   = '0;
        glitch = 1'b0;
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < div; k++) begin
                if (i != 0 || k != 0) @(negedge clk);
                if (k == 0) word[i] = tx;
                else if (tx !== word[i]) glitch = 1'b1;
            end
        end
        check_val(tag, {glitch, word}, {1'b0, 1'b1, b, 1'b0});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [63:0] trace;
        logic [63:0] exp_trace;
        logic [7:0]  d55;
        int          busy_n;
        int          n;
        bit          f;
        int          t0;
        int          t1;

        bus.wr_sig  = 1'b0;
        bus.addr    = 32'd0;
        bus.wr_data = 32'd0;

        // reset and register map
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b0;
        check_val("reset_tx", tx, 1);
        bus_rd(A_ST, rd);          check_val("reset_status", rd, 32'h1);
        bus_rd(A_DIV, rd);         check_val("reset_div", rd, 32'd4);
        bus_rd(32'h2000, rd);      check_val("miss_rd_2000", rd, 0);
        bus_rd(32'h2004, rd);      check_val("miss_rd_2004", rd, 0);
        check_val("miss_hit", bus.hit, 0);
        bus_rd(A_TX, rd);          check_val("txdata_rd", rd, 0);
        check_val("base_hit", bus.hit, 1);
        bus_wr(32'h2008, 32'd7);
        bus_wr(32'h2000, 32'hAB);
        bus_wr(A_RES, 32'hFFFF_FFFF);
        bus_rd(A_DIV, rd);         check_val("div_after_miss_wr", rd, 32'd4);
        bus_rd(A_RES, rd);         check_val("reserved_rd", rd, 0);
        bus_rd(A_ST, rd);          check_val("status_after_miss_wr", rd, 32'h1);

        // single frame 0x55, cycle-exact trace and busy span
        d55 = 8'h55;
        bus_wr(A_TX, 32'h55);
        bus.addr = A_ST;
        trace = '0;
        busy_n = 0;
        for (int j = 0; j < 45; j++) begin
            @(negedge clk);
            trace[j] = tx;
            if (bus.rd_data[2]) busy_n++;
        end
        exp_trace = '0;
        for (int j = 0; j < 45; j++) begin
            int bn;
            if (j < 2 || j >= 42) exp_trace[j] = 1'b1;
            else begin
                bn = (j - 2) / 4;
                if (bn == 0)      exp_trace[j] = 1'b0;
                else if (bn == 9) exp_trace[j] = 1'b1;
                else              exp_trace[j] = d55[bn-1];
            end
        end
        check_val("frame55_trace", trace, exp_trace);
        check_val("frame55_busy_cycles", busy_n, 40);
        bus_rd(A_ST, rd);          check_val("frame55_status_end", rd, 32'h1);

        // nine back-to-back bytes, tenth overflows
        fork
            begin
                for (int b = 1; b <= 9; b++) bus_wr(A_TX, b);
                bus.addr = A_ST;
                #1 check_val("status_after_9", bus.rd_data, 32'h6);
                bus_wr(A_TX, 32'h0A);
                bus_rd(A_ST, rd);  check_val("status_overflow", rd, 32'hE);
            end
            begin
                wait_start(20, n, f);
                check_val("burst_first_start", f, 1);
                t0 = cyc;
                verify_frame("burst_byte1", 8'h01, 4);
                for (int b = 2; b <= 9; b++) begin
                    wait_start(10, n, f);
                    t1 = cyc;
                    check_val($sformatf("burst_gap%0d", b), t1 - t0, 41);
                    t0 = t1;
                    verify_frame($sformatf("burst_byte%0d", b), 8'(b), 4);
                end
            end
        join
        wait_start(60, n, f);
        check_val("burst_no_10th", f, 0);
        bus_wr(A_ST, 32'h8);
        bus_rd(A_ST, rd);          check_val("overflow_cleared", rd, 32'h1);

        // divisor change mid-frame only affects the next frame
        fork
            begin
                bus_wr(A_TX, 32'hA5);
                bus_wr(A_TX, 32'h3C);
                repeat (12) @(negedge clk);
                bus_wr(A_DIV, 32'd2);
            end
            begin
                wait_start(20, n, f);
                t0 = cyc;
                verify_frame("frame_a5_div4", 8'hA5, 4);
                wait_start(10, n, f);
                t1 = cyc;
                check_val("a5_to_3c_gap", t1 - t0, 41);
                verify_frame("frame_3c_div2", 8'h3C, 2);
            end
        join
        bus_rd(A_DIV, rd);         check_val("div_readback", rd, 32'd2);
        fork
            begin
                bus_wr(A_DIV, 32'd0);
                bus_wr(A_TX, 32'h96);
            end
            begin
                wait_start(20, n, f);
                check_val("div0_start", f, 1);
                verify_frame("frame_96_div0", 8'h96, 1);
            end
        join

        // reset mid-frame with bytes queued
        bus_wr(A_DIV, 32'd4);
        bus_wr(A_TX, 32'hFF);
        bus_wr(A_TX, 32'h11);
        bus_wr(A_TX, 32'h22);
        bus_wr(A_TX, 32'h33);
        repeat (6) @(negedge clk);
        bus_rd(A_ST, rd);          check_val("status_mid_ff", rd, 32'h4);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("abort_tx", tx, 1);
        reset_n = 1'b0;
        bus_rd(A_ST, rd);          check_val("abort_status", rd, 32'h1);
        bus_rd(A_DIV, rd);         check_val("abort_div", rd, 32'd4);
        wait_start(100, n, f);
        check_val("abort_no_frames", f, 0);

`ifdef UART_TX_IRQ_EN
        bus_wr(A_ST, 32'h10);
        bus_rd(A_ST, rd);          check_val("irq_en_status", rd, 32'h11);
        bus_wr(A_TX, 32'h00);
        trace = '0;
        for (int j = 0; j < 50; j++) begin
            @(negedge clk);
            trace[j] = irq;
        end
        exp_trace = '0;
        exp_trace[0] = 1'b1;
        for (int j = 42; j < 50; j++) exp_trace[j] = 1'b1;
        check_val("irq_trace", trace, exp_trace);
        bus_wr(A_ST, 32'h0);
        @(negedge clk);
        check_val("irq_hold_after_clear", irq, 1);
        @(negedge clk);
        check_val("irq_dropped", irq, 0);
`else
        bus_wr(A_ST, 32'h10);
        bus_rd(A_ST, rd);          check_val("irq_en_ignored", rd, 32'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
